cwe1280_secure_reader: RTL

CWE1280_SECURE_READER -- requirements
Module: cwe1280_secure_reader

---
 rtl/cwe1280_secure_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cwe1280_secure_reader.sv
// Identity-gated reader for protected storage with lockout after
// repeated denied requests.
module cwe1280_secure_reader #(
    parameter logic [2:0] AUTH_ID     = 3'h4,
    parameter int         LOCK_THRESH = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] usr_id,
    input  logic       rd_req,
    input  logic [1:0] rd_addr,
    output logic       rd_ready,
    output logic       mem_rd_en,
    output logic [1:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_err,
    output logic       lock_active
);

    localparam int FW = $clog2(LOCK_THRESH + 1);
    localparam logic [FW-1:0] THRESH = FW'(LOCK_THRESH);
    localparam logic [7:0] CYCLES = 8'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        RESP,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic [2:0]    req_id;
    logic [1:0]    req_addr;
    logic          deny;
    logic [7:0]    data_q;
    logic [FW-1:0] fail_cnt;
    logic [7:0]    timer;
    logic          granted;

    // Identity is judged only from the value latched at the handshake.
    assign granted = (req_id == AUTH_ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        rd_ready    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = 2'd0;
        rd_valid    = 1'b0;
        rd_data     = 8'h00;
        rd_err      = 1'b0;
        lock_active = 1'b0;
        unique case (state)
            IDLE: begin
                rd_ready = 1'b1;
                if (rd_req) state_nx = CHECK;
            end
            CHECK: begin
                if (granted) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = req_addr;
                    state_nx  = FETCH;
                end else begin
                    state_nx = RESP;
                end
            end
            FETCH: state_nx = RESP;
            RESP: begin
                rd_valid = 1'b1;
                rd_err   = deny;
                rd_data  = deny ? 8'h00 : data_q;
                state_nx = (fail_cnt == THRESH) ? LOCKED : IDLE;
            end
            LOCKED: begin
                lock_active = 1'b1;
                if (timer == 8'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_id   <= 3'd0;
            req_addr <= 2'd0;
            deny     <= 1'b0;
            data_q   <= 8'h00;
            fail_cnt <= '0;
            timer    <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_req) begin
                        req_id   <= usr_id;
                        req_addr <= rd_addr;
                    end
                end
                CHECK: begin
                    deny <= !granted;
                    if (granted)
                        fail_cnt <= '0;
                    else if (fail_cnt < THRESH)
                        fail_cnt <= fail_cnt + 1'b1;
                end
                FETCH: data_q <= mem_rdata;
                RESP: begin
                    if (fail_cnt == THRESH) timer <= CYCLES;
                end
                LOCKED: begin
                    if (timer == 8'd1) begin
                        timer    <= 8'd0;
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
